// File: rtl/otter_iobus_timer_pkg.sv
// Shared constants for the OTTER IOBUS timer.
// Register offsets (word index in window) and CTRL bit positions.
package otter_timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  localparam int CTRL_W = 3;

  // Word offset inside the 32-byte window.
  function automatic logic [2:0] reg_off(
    input logic [31:0] addr
  );
    return addr[4:2];
  endfunction

endpackage

// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS bundle: CPU-side master, peripheral-side slave.
// ADDR/OUT/WR from the CPU; IN (read data) and INTR back to it.
interface otter_iobus_timer_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN,
    input  INTR
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN,
    output INTR
  );

endinterface

// File: rtl/otter_iobus_timer_prescaler.sv
// Prescale counter: pulses tick once every limit+1 enabled cycles.
// Ports: clk, rst (sync high), en, clr, limit[31:0] -> tick.
module timer_prescaler
  import otter_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] limit,
  output logic        tick
);

  logic [31:0] psc;

  assign tick = en & (psc == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (clr | ~en | tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 32'd1;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped timer with interrupt on the OTTER IOBUS.
// Ports: clk, rst (sync high), bus (slave: ADDR/OUT/WR in, IN/INTR out).
module otter_iobus_timer
  import otter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  otter_iobus_timer_if.slave   bus
);

  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       prescale;
  logic [31:0]       compare;
  logic [31:0]       count;
  logic              pend;

  logic        hit;
  logic [2:0]  off;
  logic        wr_hit;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        wr_cmp;
  logic        wr_cnt;
  logic        wr_stat;
  logic        tick;
  logic        fire;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign hit    = bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
  assign off    = reg_off(bus.IOBUS_ADDR);
  assign wr_hit = bus.IOBUS_WR & hit;

  assign wr_ctrl = wr_hit & (off == OFF_CTRL);
  assign wr_pre  = wr_hit & (off == OFF_PRESCALE);
  assign wr_cmp  = wr_hit & (off == OFF_COMPARE);
  assign wr_cnt  = wr_hit & (off == OFF_COUNT);
  assign wr_stat = wr_hit & (off == OFF_STATUS);

  assign unused_addr_lsb = ^bus.IOBUS_ADDR[1:0];

  timer_prescaler u_psc (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl[CTRL_EN]),
    .clr   (wr_ctrl | wr_pre),
    .limit (prescale),
    .tick  (tick)
  );

  // A software COUNT load suppresses the compare for that cycle.
  assign fire = tick & ~wr_cnt & (count == compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= bus.IOBUS_OUT[CTRL_W-1:0];
    end else if (fire & ~ctrl[CTRL_AR]) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_pre) prescale <= bus.IOBUS_OUT;
      if (wr_cmp) compare  <= bus.IOBUS_OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_cnt) begin
      count <= bus.IOBUS_OUT;
    end else if (fire) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // Hardware set takes priority over a software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (fire) begin
      pend <= 1'b1;
    end else if (wr_stat & bus.IOBUS_OUT[0]) begin
      pend <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (off)
        OFF_CTRL:     rdata = {29'd0, ctrl};
        OFF_PRESCALE: rdata = prescale;
        OFF_COMPARE:  rdata = compare;
        OFF_COUNT:    rdata = count;
        OFF_STATUS:   rdata = {31'd0, pend};
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.IOBUS_IN = rdata;
  assign bus.INTR     = pend & ctrl[CTRL_IE];

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer.
// Directed scenarios plus random bus traffic against a reference model.
`timescale 1ns/100ps
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  otter_iobus_timer_if bus ();

  otter_iobus_timer #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (value after the most recent edge).
  logic [2:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cmp;
  logic [31:0] m_cnt;
  logic        m_pend;
  logic [31:0] m_phase;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [2:0] o;
    if (a[31:5] != BASE[31:5]) return 32'h0;
    o = a[4:2];
    case (o)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_pre;
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {31'd0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the peripheral, applied in event-priority order.
  task automatic model_edge();
    logic        w;
    logic [2:0]  o;
    logic [31:0] d;
    logic        due;
    logic        hit_cmp;
    w = bus.IOBUS_WR && (bus.IOBUS_ADDR[31:5] == BASE[31:5]);
    o = bus.IOBUS_ADDR[4:2];
    d = bus.IOBUS_OUT;
    if (rst) begin
      m_ctrl = 0; m_pre = 0; m_cmp = 0;
      m_cnt = 0; m_pend = 0; m_phase = 0;
      return;
    end
    // A tick is due when the enabled phase has covered PRESCALE+1 cycles.
    due = m_ctrl[0] && (m_phase == m_pre);
    hit_cmp = due && !(w && o == 3) && (m_cnt == m_cmp);
    if (!m_ctrl[0] || due || (w && (o == 0 || o == 1))) m_phase = 0;
    else m_phase = m_phase + 1;
    if (w && o == 3) m_cnt = d;
    else if (hit_cmp) m_cnt = 0;
    else if (due) m_cnt = m_cnt + 1;
    if (hit_cmp) m_pend = 1;
    else if (w && o == 4 && d[0]) m_pend = 0;
    if (w && o == 0) m_ctrl = d[2:0];
    else if (hit_cmp && !m_ctrl[2]) m_ctrl[0] = 0;
    if (w && o == 1) m_pre = d;
    if (w && o == 2) m_cmp = d;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("intr", {31'd0, bus.INTR}, {31'd0, m_pend & m_ctrl[1]});
    check("rdbk", bus.IOBUS_IN, m_read(bus.IOBUS_ADDR));
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    step();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    bus.IOBUS_ADDR = a;
    #0.2;
    check(tag, bus.IOBUS_IN, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;
    m_ctrl = 0; m_pre = 0; m_cmp = 0;
    m_cnt = 0; m_pend = 0; m_phase = 0;
    do_reset();
    do_reset();

    // 1: reset state
    for (int i = 0; i < 8; i++)
      rd("rst_rd", BASE + 32'(i * 4), 32'h0);
    rd("rst_out", 32'h2000_0000, 32'h0);
    check("rst_intr", {31'd0, bus.INTR}, 32'h0);

    // 2: one-shot, period (3+1)*(4+1)
    bus_wr(BASE + 4, 3);
    bus_wr(BASE + 8, 4);
    bus_wr(BASE + 0, 3'b011);
    idle(19);
    check("os_pre", {31'd0, bus.INTR}, 32'h0);
    idle(1);
    check("os_intr", {31'd0, bus.INTR}, 32'h1);
    rd("os_pend", BASE + 16, 32'h1);
    rd("os_cnt", BASE + 12, 32'h0);
    rd("os_ctrl", BASE + 0, 32'h2);

    // 3: auto-reload
    do_reset();
    bus_wr(BASE + 4, 3);
    bus_wr(BASE + 8, 4);
    bus_wr(BASE + 0, 3'b111);
    idle(20);
    check("ar_intr1", {31'd0, bus.INTR}, 32'h1);
    idle(4);
    bus_wr(BASE + 16, 1);
    check("ar_clr", {31'd0, bus.INTR}, 32'h0);
    idle(14);
    check("ar_pre2", {31'd0, bus.INTR}, 32'h0);
    idle(1);
    check("ar_intr2", {31'd0, bus.INTR}, 32'h1);

    // 4: COUNT wrap through all-ones
    do_reset();
    bus_wr(BASE + 12, 32'hFFFF_FFFE);
    bus_wr(BASE + 8, 1);
    bus_wr(BASE + 0, 3'b001);
    step();
    rd("wr_ff", BASE + 12, 32'hFFFF_FFFF);
    step();
    rd("wr_0", BASE + 12, 32'h0);
    step();
    rd("wr_1", BASE + 12, 32'h1);
    rd("wr_np", BASE + 16, 32'h0);
    step();
    rd("wr_pend", BASE + 16, 32'h1);

    // 5: set beats clear; IE gates INTR only
    do_reset();
    bus_wr(BASE + 0, 3'b111);
    step();
    for (int i = 0; i < 5; i++) begin
      bus_wr(BASE + 16, 1);
      rd("sw_pend", BASE + 16, 32'h1);
    end
    bus_wr(BASE + 0, 3'b101);
    check("ie_off", {31'd0, bus.INTR}, 32'h0);
    rd("ie_pend", BASE + 16, 32'h1);

    // 6: reset mid-count, out-of-window stores
    bus_wr(BASE + 0, 3'b010);
    bus_wr(BASE + 8, 100);
    bus_wr(BASE + 12, 7);
    check("m_intr", {31'd0, bus.INTR}, 32'h1);
    rd("m_cnt", BASE + 12, 32'h7);
    do_reset();
    check("mr_intr", {31'd0, bus.INTR}, 32'h0);
    rd("mr_cnt", BASE + 12, 32'h0);
    rd("mr_ctrl", BASE + 0, 32'h0);
    bus_wr(BASE + 4, 5);
    for (int i = 0; i < 5; i++)
      bus_wr(BASE + 32'h20 + 32'(i * 4), 32'hFFFF_FFFF);
    rd("oow_ctrl", BASE + 0, 32'h0);
    rd("oow_pre", BASE + 4, 32'h5);
    rd("oow_cnt", BASE + 12, 32'h0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 9) == 0)
        a = $urandom;
      else
        a = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0)
        d = $urandom;
      else
        d = 32'($urandom_range(0, 7));
      bus.IOBUS_ADDR = a;
      bus.IOBUS_OUT  = d;
      bus.IOBUS_WR   = ($urandom_range(0, 3) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.IOBUS_WR = 1'b0;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
